fetch_ctrl: RTL and testbench

- Fetch sequencer for the 256x9 synchronous-read instruction memory: drives its 8-bit address and receives its 9-bit instruction one clock later.
- Presents a valid/stall instruction stream to decode.
- Handles taken branches (squash the wrong-path slot), decode stalls (hold buffer), start/halt sequencing and a retired-instruction counter.

---
 rtl/fetch_ctrl_if.sv | 32 +++
 rtl/fetch_ctrl.sv | 111 +++++++++++
 tb/tb_fetch_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Bundle between the fetch sequencer, the instruction memory, decode and the
// start/halt control. The master modport is the fetch controller's view.
interface fetch_ctrl_if #(
  parameter int PC_W   = 8,
  parameter int INST_W = 9,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [PC_W-1:0]   start_pc;
  logic [PC_W-1:0]   imem_pc;
  logic [INST_W-1:0] imem_inst;
  logic [INST_W-1:0] inst_out;
  logic [PC_W-1:0]   inst_pc;
  logic              inst_valid;
  logic              stall;
  logic              branch_taken;
  logic [PC_W-1:0]   branch_target;
  logic              halt;
  logic              running;
  logic              done;
  logic [CNT_W-1:0]  retire_count;

  modport master (
    input  start, start_pc, imem_inst, stall, branch_taken, branch_target, halt,
    output imem_pc, inst_out, inst_pc, inst_valid, running, done, retire_count
  );

  modport slave (
    output start, start_pc, imem_inst, stall, branch_taken, branch_target, halt,
    input  imem_pc, inst_out, inst_pc, inst_valid, running, done, retire_count
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer for a synchronous-read instruction memory: streams
// instructions to decode with stall hold, branch squash and halt/restart.
module fetch_ctrl #(
  parameter int PC_W   = 8,
  parameter int INST_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   fetch_pc_q;
  logic [INST_W-1:0] hold_inst_q;
  logic [PC_W-1:0]   hold_pc_q;
  logic              hold_q;
  logic              valid_q;
  logic              running_q;
  logic              done_q;
  logic [CNT_W-1:0]  retire_q;

  // In RUN, valid_q low means the squash bubble that follows a taken branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      fetch_pc_q  <= '0;
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
      hold_q      <= 1'b0;
      valid_q     <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      retire_q    <= '0;
    end else begin
      case (state_q)
        IDLE, HALTED: begin
          if (bus.start) begin
            state_q   <= FILL;
            pc_q      <= bus.start_pc;
            retire_q  <= '0;
            hold_q    <= 1'b0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end

        FILL: begin
          state_q    <= RUN;
          pc_q       <= pc_q + 1'b1;
          fetch_pc_q <= pc_q;
          valid_q    <= 1'b1;
        end

        RUN: begin
          fetch_pc_q <= pc_q;
          if (!valid_q) begin
            pc_q    <= pc_q + 1'b1;
            valid_q <= 1'b1;
          end else if (bus.stall) begin
            // Capture only on the first stalled cycle; later memory reads
            // re-fetch the held-back address and are discarded.
            if (!hold_q) begin
              hold_q      <= 1'b1;
              hold_inst_q <= bus.imem_inst;
              hold_pc_q   <= fetch_pc_q;
            end
          end else begin
            hold_q <= 1'b0;
            if (retire_q != {CNT_W{1'b1}}) begin
              retire_q <= retire_q + 1'b1;
            end
            if (bus.halt) begin
              state_q   <= HALTED;
              valid_q   <= 1'b0;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else if (bus.branch_taken) begin
              pc_q    <= bus.branch_target;
              valid_q <= 1'b0;
            end else begin
              pc_q <= pc_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.imem_pc      = pc_q;
  assign bus.inst_out     = hold_q ? hold_inst_q : bus.imem_inst;
  assign bus.inst_pc      = hold_q ? hold_pc_q : fetch_pc_q;
  assign bus.inst_valid   = valid_q;
  assign bus.running      = running_q;
  assign bus.done         = done_q;
  assign bus.retire_count = retire_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a stimulus process queues the expected
// instruction stream, a negedge monitor checks every presented instruction.
module tb_fetch_ctrl;

  localparam int PC_W   = 8;
  localparam int INST_W = 9;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t expq[$];
  logic [INST_W-1:0] mem [256];

  fetch_ctrl_if #(.PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)) bus ();

  fetch_ctrl #(.PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory model.
  always @(posedge clk) begin
    bus.imem_inst <= mem[bus.imem_pc];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs just after a rising edge and returns just
  // after the edge that sampled them.
  task automatic applyStimulus(input logic st, input logic [PC_W-1:0] spc, input logic stl,
                               input logic br, input logic [PC_W-1:0] tgt, input logic hl,
                               input logic rst);
    bus.start         = st;
    bus.start_pc      = spc;
    bus.stall         = stl;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.halt          = hl;
    reset             = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pushExp(input logic [INST_W-1:0] inst, input logic [PC_W-1:0] pc);
    exp_t e;
    e.inst = inst;
    e.pc   = pc;
    expq.push_back(e);
  endtask

  // Scoreboard monitor: stalled cycles compare the queue head, consumes pop it.
  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
    end else if (bus.inst_valid) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_inst: got 0x%0h@0x%0h, expected no instruction",
                 bus.inst_out, bus.inst_pc);
      end else begin
        checkOutput("inst_out", 32'(bus.inst_out), 32'(expq[0].inst));
        checkOutput("inst_pc", 32'(bus.inst_pc), 32'(expq[0].pc));
        if (!bus.stall) void'(expq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 9'h000;
    mem[8'h10] = 9'h1A1;
    mem[8'h11] = 9'h0B2;
    mem[8'h12] = 9'h1C3;
    mem[8'h13] = 9'h0D4;
    mem[8'h40] = 9'h140;
    mem[8'h41] = 9'h041;
    mem[8'h05] = 9'h155;
    mem[8'h06] = 9'h066;
    mem[8'hFE] = 9'h1FE;
    mem[8'hFF] = 9'h0FF;
    mem[8'h00] = 9'h100;
    mem[8'h01] = 9'h011;

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    idleCycle();
    checkOutput("rst_imem_pc", 32'(bus.imem_pc), 32'h0);
    checkOutput("rst_valid", 32'(bus.inst_valid), 32'h0);
    checkOutput("rst_running", 32'(bus.running), 32'h0);
    checkOutput("rst_done", 32'(bus.done), 32'h0);
    checkOutput("rst_retire", 32'(bus.retire_count), 32'h0);

    // Start at 0x10, stall on B, branch on C, then halt+branch on 0x41.
    pushExp(9'h1A1, 8'h10);
    pushExp(9'h0B2, 8'h11);
    pushExp(9'h1C3, 8'h12);
    pushExp(9'h140, 8'h40);
    pushExp(9'h041, 8'h41);
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("fill_valid", 32'(bus.inst_valid), 32'h0);
    checkOutput("fill_imem_pc", 32'(bus.imem_pc), 32'h10);
    checkOutput("fill_running", 32'(bus.running), 32'h1);
    idleCycle();
    checkOutput("run_valid", 32'(bus.inst_valid), 32'h1);
    idleCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
      checkOutput("stall_imem_pc", 32'(bus.imem_pc), 32'h12);
      checkOutput("stall_retire", 32'(bus.retire_count), 32'h1);
      checkOutput("stall_done", 32'(bus.done), 32'h0);
    end
    idleCycle();
    checkOutput("release_retire", 32'(bus.retire_count), 32'h2);
    checkOutput("release_imem_pc", 32'(bus.imem_pc), 32'h13);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
    checkOutput("retire_after_c", 32'(bus.retire_count), 32'h3);
    checkOutput("squash_valid", 32'(bus.inst_valid), 32'h0);
    checkOutput("branch_imem_pc", 32'(bus.imem_pc), 32'h40);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("post_squash_imem_pc", 32'(bus.imem_pc), 32'h41);
    checkOutput("post_squash_retire", 32'(bus.retire_count), 32'h3);
    idleCycle();
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0);
    checkOutput("halt_done", 32'(bus.done), 32'h1);
    checkOutput("halt_running", 32'(bus.running), 32'h0);
    checkOutput("halt_valid", 32'(bus.inst_valid), 32'h0);
    checkOutput("halt_retire", 32'(bus.retire_count), 32'h5);
    checkOutput("halt_no_redirect", 32'(bus.imem_pc == 8'h80), 32'h0);
    idleCycle();
    checkOutput("halted_done", 32'(bus.done), 32'h1);
    checkOutput("halted_no_redirect", 32'(bus.imem_pc == 8'h80), 32'h0);

    // Restart from HALTED at 0x05.
    pushExp(9'h155, 8'h05);
    pushExp(9'h066, 8'h06);
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("restart_retire", 32'(bus.retire_count), 32'h0);
    checkOutput("restart_imem_pc", 32'(bus.imem_pc), 32'h05);
    checkOutput("restart_done", 32'(bus.done), 32'h0);
    idleCycle();
    idleCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("halt2_retire", 32'(bus.retire_count), 32'h2);
    checkOutput("halt2_done", 32'(bus.done), 32'h1);

    // Wrap-around from 0xFE, then reset during a held stall.
    pushExp(9'h1FE, 8'hFE);
    pushExp(9'h0FF, 8'hFF);
    pushExp(9'h100, 8'h00);
    pushExp(9'h011, 8'h01);
    applyStimulus(1'b1, 8'hFE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("wrap_fill_pc", 32'(bus.imem_pc), 32'hFE);
    idleCycle();
    idleCycle();
    checkOutput("wrap_imem_pc", 32'(bus.imem_pc), 32'h00);
    idleCycle();
    idleCycle();
    checkOutput("wrap_retire", 32'(bus.retire_count), 32'h3);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h10, 1'b1, 1'b1, 8'h40, 1'b0, 1'b1);
    checkOutput("mid_rst_imem_pc", 32'(bus.imem_pc), 32'h0);
    checkOutput("mid_rst_valid", 32'(bus.inst_valid), 32'h0);
    checkOutput("mid_rst_running", 32'(bus.running), 32'h0);
    checkOutput("mid_rst_done", 32'(bus.done), 32'h0);
    checkOutput("mid_rst_retire", 32'(bus.retire_count), 32'h0);
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      checkOutput("idle_valid", 32'(bus.inst_valid), 32'h0);
      checkOutput("idle_imem_pc", 32'(bus.imem_pc), 32'h0);
    end

    checkOutput("queue_drained", 32'(expq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
